key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter_pkg.sv | 12 +
 rtl/key_sync.sv | 60 ++++++
 rtl/key_filter.sv | 103 ++++++++++
 tb/tb_key_filter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// Shared widths and constants for the key debouncer.
`timescale 1ns/1ps
package key_filter_pkg;

    localparam int unsigned CNT_W       = 20;
    localparam int unsigned SYNC_STAGES = 2;

    // Cycles after reset until the synchronizer and delay register hold real samples.
    localparam int unsigned FLUSH_W = 2;
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(3);

endpackage

// File: rtl/key_sync.sv
// Synchronizes the raw key into the clock domain and emits registered edge strobes.
`timescale 1ns/1ps
module key_sync
    import key_filter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic nedge_o,
    output logic pedge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;
    logic                   key_s_dly_q;
    logic [FLUSH_W-1:0]     flush_q;
    logic [FLUSH_W-1:0]     flush_d;
    logic                   armed_q;
    logic                   armed_d;
    logic                   nedge_q;
    logic                   nedge_d;
    logic                   pedge_q;
    logic                   pedge_d;

    assign key_s = sync_q[SYNC_STAGES-1];

    // Falling edges stay blocked until a released level has been seen after reset,
    // so a key held down across reset release never looks like a fresh press.
    always_comb begin
        flush_d = flush_q;
        if (flush_q != FLUSH_DONE) begin
            flush_d = flush_q + FLUSH_W'(1);
        end
        armed_d = armed_q | ((flush_q == FLUSH_DONE) & key_s);
        nedge_d = armed_q & key_s_dly_q & ~key_s;
        pedge_d = ~key_s_dly_q & key_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            key_s_dly_q <= 1'b1;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            nedge_q     <= 1'b0;
            pedge_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], key_i};
            key_s_dly_q <= key_s;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            nedge_q     <= nedge_d;
            pedge_q     <= pedge_d;
        end
    end

    assign nedge_o = nedge_q;
    assign pedge_o = pedge_q;

endmodule

// File: rtl/key_filter.sv
// Debounces a mechanical key: a level must hold CNT_MAX+1 counts before it is accepted.
`timescale 1ns/1ps
module key_filter
    import key_filter_pkg::*;
#(
    parameter int unsigned CNT_MAX = 999_999
) (
    input  logic Clk50M,
    input  logic Rst_n,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] FILTER0 = 2'b01;
    localparam logic [1:0] DOWN    = 2'b10;
    localparam logic [1:0] FILTER1 = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

    logic             nedge;
    logic             pedge;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             flag_q;
    logic             flag_d;
    logic             key_state_q;
    logic             key_state_d;

    key_sync u_key_sync (
        .clk     (Clk50M),
        .rst_n   (Rst_n),
        .key_i   (key_in),
        .nedge_o (nedge),
        .pedge_o (pedge)
    );

    // Counter defaults to zero, so it clears on every transition and idles at zero.
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        flag_d      = 1'b0;
        key_state_d = key_state_q;
        case (state_q)
            IDLE: begin
                if (nedge) begin
                    state_d = FILTER0;
                end
            end
            FILTER0: begin
                if (pedge) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DOWN;
                    flag_d      = 1'b1;
                    key_state_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (pedge) begin
                    state_d = FILTER1;
                end
            end
            FILTER1: begin
                if (nedge) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    flag_d      = 1'b1;
                    key_state_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            key_state_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            key_state_q <= key_state_d;
        end
    end

    assign key_flag  = flag_q;
    assign key_state = key_state_q;

endmodule

// File: tb/tb_key_filter.sv
// Directed/randomized bench for key_filter with a run-length reference model.
`timescale 1ns/1ps
module tb_key_filter;

    localparam int unsigned CNT_MAX = 24_999;
    localparam int unsigned RUN_REQ = CNT_MAX + 2;
    localparam int unsigned LAT     = CNT_MAX + 4;

    logic Clk50M;
    logic Rst_n;
    logic key_in;
    logic key_flag;
    logic key_state;

    key_filter #(.CNT_MAX(CNT_MAX)) dut (
        .Clk50M    (Clk50M),
        .Rst_n     (Rst_n),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_state (key_state)
    );

    initial Clk50M = 1'b0;
    always #10 Clk50M = ~Clk50M;

    int unsigned cyc = 0;
    always @(posedge Clk50M) cyc <= cyc + 1;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned flag_cnt = 0;
    int unsigned last_flag_cyc = 0;

    // Reference: a new level is accepted once it has been sampled on RUN_REQ
    // consecutive edges; flag and level show up three edges after the last one.
    logic        m_lvl;
    logic        m_d;
    logic        m_armed;
    int unsigned m_run;
    logic [2:0]  p_acc;
    logic [2:0]  p_lvl;
    logic        exp_flag;
    logic        exp_state;

    always @(posedge Clk50M or negedge Rst_n) begin : model
        logic        lvl_n;
        int unsigned run_n;
        logic        acc;
        if (!Rst_n) begin
            m_lvl     <= 1'b1;
            m_d       <= 1'b1;
            m_armed   <= 1'b0;
            m_run     <= RUN_REQ;
            p_acc     <= '0;
            p_lvl     <= '1;
            exp_flag  <= 1'b0;
            exp_state <= 1'b1;
        end else begin
            if (key_in != m_lvl) begin
                lvl_n = key_in;
                run_n = 1;
            end else begin
                lvl_n = m_lvl;
                run_n = (m_run < RUN_REQ) ? m_run + 1 : m_run;
            end
            if (!m_armed && !lvl_n) run_n = 0;
            acc = (run_n == RUN_REQ) && (lvl_n != m_d);
            m_lvl   <= lvl_n;
            m_run   <= run_n;
            m_armed <= m_armed | key_in;
            if (acc) m_d <= lvl_n;
            p_acc <= {p_acc[1:0], acc};
            p_lvl <= {p_lvl[1:0], lvl_n};
            exp_flag <= p_acc[2];
            if (p_acc[2]) exp_state <= p_lvl[2];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: compare both outputs against the model at the falling edge.
    task automatic tick();
        @(negedge Clk50M);
        n_assert++;
        assert (key_flag === exp_flag) else begin
            n_fail++;
            $error("FAIL cyc_flag cyc=%0d observed=%b expected=%b", cyc, key_flag, exp_flag);
        end
        n_assert++;
        assert (key_state === exp_state) else begin
            n_fail++;
            $error("FAIL cyc_state cyc=%0d observed=%b expected=%b", cyc, key_state, exp_state);
        end
        if (key_flag === 1'b1) begin
            flag_cnt++;
            last_flag_cyc = cyc;
        end
    endtask

    // Odd number of random-length toggles ending at the opposite level.
    task automatic bounce(output int unsigned e_last);
        int unsigned n;
        n = 2 * $urandom_range(20, 50) + 1;
        e_last = 0;
        for (int i = 0; i < int'(n); i++) begin
            key_in = ~key_in;
            e_last = cyc + 1;
            if (i != int'(n) - 1) repeat ($urandom_range(10, 80)) tick();
        end
    endtask

    task automatic wait_flag(input int unsigned max_cyc, input string tag);
        int unsigned start;
        start = flag_cnt;
        for (int i = 0; i < int'(max_cyc) && flag_cnt == start; i++) tick();
        chk(tag, flag_cnt - start, 1);
    endtask

    initial begin
        int unsigned e_last;
        logic        hit;

        Rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (3) tick();
        chk("reset_flag", 32'(key_flag), 0);
        chk("reset_state", 32'(key_state), 1);
        chk("reset_fsm", 32'(dut.state_q), 0);
        chk("reset_cnt", 32'(dut.cnt_q), 0);
        Rst_n = 1'b1;
        repeat (10) tick();

        // Short glitch: never accepted.
        key_in = 1'b0;
        repeat (20_000) tick();
        key_in = 1'b1;
        repeat (100) tick();
        chk("glitch_flags", flag_cnt, 0);
        chk("glitch_state", 32'(key_state), 1);
        chk("glitch_fsm_idle", 32'(dut.state_q), 0);

        // Reset in the middle of a press filter.
        key_in = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 12_000 && !hit; i++) begin
            tick();
            if (dut.cnt_q == 20'd10_000) hit = 1'b1;
        end
        chk("mid_reach_cnt", 32'(hit), 1);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_flag", 32'(key_flag), 0);
        chk("mid_rst_state", 32'(key_state), 1);
        chk("mid_rst_cnt", 32'(dut.cnt_q), 0);
        chk("mid_rst_fsm", 32'(dut.state_q), 0);
        key_in = 1'b1;
        repeat (5) tick();
        Rst_n = 1'b1;
        repeat (300) tick();
        chk("mid_no_flag", flag_cnt, 0);

        // Key held down across reset release.
        key_in = 1'b0;
        Rst_n  = 1'b0;
        repeat (5) tick();
        Rst_n = 1'b1;
        repeat (100) tick();
        chk("hold_fsm_idle", 32'(dut.state_q), 0);
        chk("hold_cnt", 32'(dut.cnt_q), 0);
        chk("hold_flags", flag_cnt, 0);
        key_in = 1'b1;
        repeat (50) tick();
        chk("hold_rise_idle", 32'(dut.state_q), 0);

        // Bouncy press.
        bounce(e_last);
        wait_flag(LAT + 100, "press_flag");
        chk("press_latency", last_flag_cyc - e_last, LAT);
        chk("press_state", 32'(key_state), 0);
        repeat (50) tick();
        chk("press_single", flag_cnt, 1);

        // Bouncy release.
        bounce(e_last);
        wait_flag(LAT + 100, "release_flag");
        chk("release_latency", last_flag_cyc - e_last, LAT);
        chk("release_state", 32'(key_state), 1);
        repeat (50) tick();
        chk("total_flags", flag_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
